imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the fetch path: accepts decoded instruction fields (rd, rs1, rs2, imm, funct) over a valid/ready stream.
- Encodes each field set into a 32-bit RV32 word.
- Writes the words sequentially into the instruction memory's write port, stepping the byte address by 4, the same stride the PC uses.
- Used to program the instruction memory before the core starts fetching.

Parameters:
ADDR_W, 7, byte address width (matches PC width; 32 words)
DATA_W, 32, instruction word width
OPC_R, 7'h33, opcode emitted for R-type
OPC_I, 7'h13, opcode emitted for I-type
OPC_S, 7'h23, opcode emitted for S-type

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse: begin a load session
start_addr  in  ADDR_W  first byte address; bits [1:0] forced to 0
in_valid  in  1  field set valid
in_ready  out  1  loader accepts a field set this cycle
in_last  in  1  final field set of the session
in_fmt  in  2  00 R, 01 I, 10 S, 11 illegal
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R only)
in_imm  in  12  immediate (I/S)
mem_we  out  1  write strobe, one cycle per word
mem_addr  out  ADDR_W  write byte address
mem_wdata  out  DATA_W  encoded word
busy  out  1  session active (LOAD or DRAIN)
done  out  1  one-cycle pulse at session end
err_fmt  out  1  sticky: an illegal format was received
err_full  out  1  sticky: address space exhausted before in_last
word_count  out  6  words written this session (0..32)

Behaviour:
- Reset (rst=0, asynchronous) takes effect immediately:
  - state=IDLE.
  - mem_we, done, in_ready, busy, err_fmt, err_full = 0.
  - mem_addr=0, mem_wdata=0, word_count=0.
- FSM states: IDLE, LOAD, DRAIN, DONE. in_ready = (state==LOAD), taken from registered state only.
- IDLE:
  - On start: wr_ptr={start_addr[6:2],2'b00}; clear word_count, err_fmt and err_full; go to LOAD.
  - start is ignored in every other state.
- LOAD, on accept (in_valid & in_ready) in cycle N:
  - Cycle N+1: mem_we=1, mem_addr=wr_ptr, mem_wdata=encoded word, word_count increments.
  - wr_ptr advances by 4 on the same edge.
  - Back-to-back accepts give one write per cycle.
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, OPC_R}
  - I: {imm[11:0], rs1, funct3, rd, OPC_I}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_S}
- Illegal fmt (11):
  - The field set is consumed, but mem_we stays 0 and wr_ptr and word_count are unchanged.
  - err_fmt is set.
  - If in_last is also set, the session still terminates.
- Termination:
  - Accept with in_last=1 goes to DRAIN.
  - Accept at wr_ptr==124 with in_last=0 goes to DRAIN and sets err_full.
  - Accept at 124 with in_last=1 goes to DRAIN with no error.
- DRAIN: in_ready=0; the final write is issued this cycle. Next state is DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start to first in_ready is 1 cycle. Last accept to done is 2 cycles.
- Address arithmetic is modulo 2^ADDR_W. The wrap is prevented by the err_full stop, so it never occurs in a session.
- err_fmt, err_full and word_count hold their values in IDLE until the next start.
- Reset mid-session aborts it. An in-flight write is dropped and no done pulse is produced.

Decomposition:
- Shared package holds:
  - Opcode constants (OPC_R/I/S).
  - Format encodings (FMT_R=2'b00, FMT_I, FMT_S, FMT_BAD).
  - Field bit positions (RD_LSB=7, RS1_LSB=15, RS2_LSB=20, IMM_LSB=20), shared with the instruction-memory decoder.
- One combinational sub-module, instr_encoder: fields + fmt → 32-bit word + illegal flag.
- The FSM, write pointer and output register stay in imem_loader.

Test Plan:
- Load 3 I-type words:
  - Stimulus: start, start_addr=0, then rd=1,rs1=2,imm=5,f3=0; rd=3,rs1=1,imm=-1; last with rd=4.
  - Response: writes at 0, 4, 8. Word 0 = 32'h00510093; word 1 = 32'hFFF08193. done 2 cycles after the last accept; word_count=3.
- R and S encoding:
  - R: rd=5,rs1=6,rs2=7,f3=0,f7=0x20 → 32'h407302B3.
  - S: rs1=2,rs2=8,imm=12'h024,f3=2 → 32'h02812223.
- Illegal fmt mid-stream:
  - Stimulus: R, fmt=11, R(last), start_addr=16.
  - Response: exactly 2 writes, at 16 and 20. err_fmt=1; word_count=2.
- Capacity:
  - Stimulus: start_addr=120, stream 4 words without last.
  - Response: writes at 120 and 124. in_ready drops after the 2nd accept; err_full=1; done pulses.
- Backpressure and misalignment:
  - Stimulus: in_valid toggled every other cycle; start_addr=7'd6.
  - Response: first write at 4, no duplicate or skipped writes. A start while busy is ignored.
- Async reset during a write cycle:
  - Response: mem_we falls without waiting for a clock edge; all outputs reach reset values; no done pulse.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader and the instruction-memory decoder.
// Opcodes, field formats, RV32 field positions and the loader state encoding.
package imem_loader_pkg;

  localparam logic [6:0] OPC_R = 7'h33;
  localparam logic [6:0] OPC_I = 7'h13;
  localparam logic [6:0] OPC_S = 7'h23;

  typedef enum logic [1:0] {
    FMT_R   = 2'b00,
    FMT_I   = 2'b01,
    FMT_S   = 2'b10,
    FMT_BAD = 2'b11
  } fmt_e;

  // Bit positions inside a 32-bit RV32 word; the decoder slices with the same values.
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int IMM_LSB = 20;
  localparam int F7_LSB  = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/imem_loader_instr_encoder.sv
// Combinational RV32 encoder: one decoded field set in, one 32-bit word out.
// The illegal flag is raised for the reserved format code; the word is zero then.
module instr_encoder #(
  parameter logic [6:0] OPC_R = imem_loader_pkg::OPC_R,
  parameter logic [6:0] OPC_I = imem_loader_pkg::OPC_I,
  parameter logic [6:0] OPC_S = imem_loader_pkg::OPC_S
) (
  input  logic [1:0]  fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        illegal
);
  import imem_loader_pkg::*;

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: begin
        word[6:0]           = OPC_R;
        word[RD_LSB +: 5]   = rd;
        word[F3_LSB +: 3]   = funct3;
        word[RS1_LSB +: 5]  = rs1;
        word[RS2_LSB +: 5]  = rs2;
        word[F7_LSB +: 7]   = funct7;
      end
      FMT_I: begin
        word[6:0]           = OPC_I;
        word[RD_LSB +: 5]   = rd;
        word[F3_LSB +: 3]   = funct3;
        word[RS1_LSB +: 5]  = rs1;
        word[IMM_LSB +: 12] = imm;
      end
      FMT_S: begin
        // S-type splits the immediate around the register fields.
        word[6:0]           = OPC_S;
        word[RD_LSB +: 5]   = imm[4:0];
        word[F3_LSB +: 3]   = funct3;
        word[RS1_LSB +: 5]  = rs1;
        word[RS2_LSB +: 5]  = rs2;
        word[F7_LSB +: 7]   = imm[11:5];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Streams decoded field sets into the instruction memory write port, one word per accept,
// at consecutive word addresses starting from a word-aligned start address.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; error flags and word_count hold last result
// ST_LOAD  | in_ready high, each accept produces one write next cycle
// ST_DRAIN | final write of the session is on the memory port
// ST_DONE  | done pulse, then back to idle
module imem_loader #(
  parameter int         ADDR_W = 7,
  parameter int         DATA_W = 32,
  parameter logic [6:0] OPC_R  = imem_loader_pkg::OPC_R,
  parameter logic [6:0] OPC_I  = imem_loader_pkg::OPC_I,
  parameter logic [6:0] OPC_S  = imem_loader_pkg::OPC_S
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [11:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_fmt,
  output logic              err_full,
  output logic [5:0]        word_count
);
  import imem_loader_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              accept;
  logic              at_last_addr;

  instr_encoder #(
    .OPC_R (OPC_R),
    .OPC_I (OPC_I),
    .OPC_S (OPC_S)
  ) u_encoder (
    .fmt     (in_fmt),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .imm     (in_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign in_ready     = (state == ST_LOAD);
  assign busy         = (state == ST_LOAD) || (state == ST_DRAIN);
  assign done         = (state == ST_DONE);
  assign accept       = in_valid && in_ready;
  // Only a real write at the top word exhausts the space; a dropped illegal set does not.
  assign at_last_addr = (wr_ptr == LAST_ADDR) && !enc_illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  if (accept && (in_last || at_last_addr)) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      err_fmt    <= 1'b0;
      err_full   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (state == ST_IDLE && start) begin
        wr_ptr     <= {start_addr[ADDR_W-1:2], 2'b00};
        word_count <= '0;
        err_fmt    <= 1'b0;
        err_full   <= 1'b0;
      end else if (accept) begin
        if (enc_illegal) begin
          err_fmt <= 1'b1;
        end else begin
          mem_we     <= 1'b1;
          mem_addr   <= wr_ptr;
          mem_wdata  <= DATA_W'(enc_word);
          word_count <= word_count + 6'd1;
          wr_ptr     <= wr_ptr + ADDR_W'(4);
          if (at_last_addr && !in_last) err_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a field-level model predicts every memory write,
// the flags and the session timing; a negedge monitor compares each write.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  start_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [1:0]  in_fmt;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [11:0] in_imm;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy, done, err_fmt, err_full;
  logic [5:0]  word_count;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_fmt     (in_fmt),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err_fmt    (err_fmt),
    .err_full   (err_full),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t seen[$];

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned m_ptr, m_wc;
  bit          m_errf, m_full, ended;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Field placement by weight: bit position p contributes value * 2**p.
  function automatic logic [31:0] model_word(input int unsigned fmt, rd, rs1, rs2, f3, f7, imm);
    int unsigned w;
    w = 0;
    case (fmt)
      0: w = 32'h33 + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 32'h100000 + f7 * 32'h2000000;
      1: w = 32'h13 + rd * 128 + f3 * 4096 + rs1 * 32768 + imm * 32'h100000;
      2: w = 32'h23 + (imm % 32) * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 32'h100000
             + (imm / 32) * 32'h2000000;
      default: w = 0;
    endcase
    return w;
  endfunction

  always @(negedge clk) begin : write_monitor
    wr_t w, e;
    if (rst === 1'b1 && mem_we === 1'b1) begin
      w.a = mem_addr;
      w.d = mem_wdata;
      seen.push_back(w);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write addr=%0d data=%h required=no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {25'd0, mem_addr}, {25'd0, e.a});
        check("wr_data", mem_wdata, e.d);
      end
    end
  end

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic start_session(input int unsigned addr);
    start      = 1'b1;
    start_addr = 7'(addr);
    seen.delete();
    @(posedge clk); #1;
    start  = 1'b0;
    m_ptr  = addr & 32'h7c;
    m_wc   = 0;
    m_errf = 0;
    m_full = 0;
    ended  = 0;
    @(negedge clk);
    check("start_ready", in_ready, 1);
    check("start_busy", busy, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input int unsigned fmt, rd, rs1, rs2, f3, f7, imm, input bit last);
    wr_t e;
    in_valid  = 1'b1;
    in_fmt    = 2'(fmt);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = 12'(imm);
    in_last   = last;
    @(negedge clk);
    check("load_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (fmt == 3) begin
      m_errf = 1;
    end else begin
      e.a = 7'(m_ptr);
      e.d = model_word(fmt, rd, rs1, rs2, f3, f7, imm);
      exp_q.push_back(e);
      m_wc++;
      if (m_ptr == 124 && !last) begin
        m_full = 1;
        ended  = 1;
      end
      m_ptr = (m_ptr + 4) % 128;
    end
    if (last) ended = 1;
  endtask

  task automatic finish_session();
    check("session_ended", 32'(ended), 1);
    @(negedge clk);
    check("drain_ready", in_ready, 0);
    check("drain_busy", busy, 1);
    check("drain_done", done, 0);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    @(negedge clk);
    check("done_clear", done, 0);
    check("word_count", {26'd0, word_count}, m_wc);
    check("err_fmt", err_fmt, 32'(m_errf));
    check("err_full", err_full, 32'(m_full));
    check("writes_pending", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_addr", {25'd0, mem_addr}, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_count", {26'd0, word_count}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // three I-type words from address 0
    start_session(0);
    send(1, 1, 2, 0, 0, 0, 5, 0);
    send(1, 3, 1, 0, 0, 0, 12'hFFF, 0);
    send(1, 4, 0, 0, 0, 0, 0, 1);
    finish_session();
    check("i_count", 32'(seen.size()), 3);
    if (seen.size() == 3) begin
      check("i_word0", seen[0].d, 32'h00510093);
      check("i_word1", seen[1].d, 32'hFFF08193);
      check("i_addr1", {25'd0, seen[1].a}, 4);
      check("i_addr2", {25'd0, seen[2].a}, 8);
    end
    check("i_wc_lit", {26'd0, word_count}, 3);

    // R and S encodings
    start_session(32);
    send(0, 5, 6, 7, 0, 'h20, 0, 0);
    send(2, 0, 2, 8, 2, 0, 'h024, 1);
    finish_session();
    check("rs_count", 32'(seen.size()), 2);
    if (seen.size() == 2) begin
      check("r_word", seen[0].d, 32'h407302B3);
      check("s_word", seen[1].d, 32'h02812223);
    end

    // illegal format mid-stream
    start_session(16);
    send(0, 1, 2, 3, 0, 0, 0, 0);
    send(3, 9, 9, 9, 1, 1, 1, 0);
    send(0, 9, 10, 11, 7, 0, 0, 1);
    finish_session();
    check("bad_count", 32'(seen.size()), 2);
    if (seen.size() == 2) begin
      check("bad_addr0", {25'd0, seen[0].a}, 16);
      check("bad_addr1", {25'd0, seen[1].a}, 20);
    end
    check("bad_errf_lit", err_fmt, 1);
    check("bad_wc_lit", {26'd0, word_count}, 2);

    // capacity: stream continues past the top word, loader must stop
    start_session(120);
    send(1, 1, 1, 0, 0, 0, 1, 0);
    send(1, 2, 2, 0, 0, 0, 2, 0);
    in_valid = 1'b1;
    in_fmt   = 2'b01;
    finish_session();
    in_valid = 1'b0;
    check("full_count", 32'(seen.size()), 2);
    if (seen.size() == 2) begin
      check("full_addr0", {25'd0, seen[0].a}, 120);
      check("full_addr1", {25'd0, seen[1].a}, 124);
    end
    check("full_lit", err_full, 1);
    @(posedge clk); #1;
    check("full_held_idle", err_full, 1);

    // misaligned start, gaps between field sets, start while busy
    start_session(6);
    send(0, 1, 1, 1, 0, 0, 0, 0);
    start = 1'b1; start_addr = 7'd0;
    @(posedge clk); #1;
    start = 1'b0;
    send(1, 2, 2, 0, 3, 0, 'h7FF, 0);
    @(posedge clk); #1;
    send(2, 0, 3, 4, 1, 0, 'hABC, 1);
    finish_session();
    check("bp_count", 32'(seen.size()), 3);
    if (seen.size() == 3) begin
      check("bp_addr0", {25'd0, seen[0].a}, 4);
      check("bp_addr1", {25'd0, seen[1].a}, 8);
      check("bp_addr2", {25'd0, seen[2].a}, 12);
    end

    // asynchronous reset while a write is on the port
    start_session(0);
    send(1, 1, 2, 0, 0, 0, 5, 0);
    check("pre_rst_we", mem_we, 1);
    #1 rst = 1'b0;
    #1;
    exp_q.delete();
    check("arst_we", mem_we, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", in_ready, 0);
    check("arst_done", done, 0);
    check("arst_addr", {25'd0, mem_addr}, 0);
    check("arst_wdata", mem_wdata, 0);
    check("arst_count", {26'd0, word_count}, 0);
    repeat (3) begin
      @(negedge clk);
      check("arst_no_done", done, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
